// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the FIFO family of blocks.
//   FIFO_DW / FIFO_AW : default data width and address width of the FIFO itself
//   RD_STREAM_DW      : default data width of the read-side stream adapter
//   XFER_CNT_W        : width of the optional delivered-word counter
//   occ_e             : occupancy of the 2-entry read-side output buffer
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DW      = 8;
    localparam int FIFO_AW      = 4;
    localparam int RD_STREAM_DW = FIFO_DW;
    localparam int XFER_CNT_W   = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// ---------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry in-order buffer sitting between the FIFO read port and the
// valid/ready stream. Entry "head" is always the oldest word.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at the tail this edge
//   push_data   : word to write
//   pop         : head word is consumed this edge
//   head_data   : oldest stored word (registered)
//   occ         : current occupancy EMPTY / ONE / TWO (registered)
// ---------------------------------------------------------------------------
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DW = RD_STREAM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output occ_e          occ
);

    occ_e          occ_q, occ_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;

    // Next-state for occupancy and the two storage slots. When a push and a
    // pop coincide with one word stored, the new word replaces the head
    // directly so order is kept without shifting through the tail slot.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d = push_data;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_d = push_data;
                        occ_d  = OCC_TWO;
                    end
                    2'b01: occ_d  = OCC_EMPTY;
                    2'b11: head_d = push_data;
                    default: ;
                endcase
            end
            OCC_TWO: begin
                // The upstream request rule keeps push from arriving here
                // without a pop; the push-and-pop case still keeps order.
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        occ_d = OCC_ONE;
                    end
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    // State registers; reset empties the buffer and clears the head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head_data = head_q;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
// Converts a FIFO read port (request, data one cycle later) into a
// valid/ready stream with full throughput and registered outputs.
// Ports:
//   I_CLK, I_RST_N : clock, asynchronous active-low reset
//   O_RD_REQ       : read request to the FIFO
//   I_RD_DATA      : FIFO read data, valid one cycle after an accepted request
//   I_RD_EMPTY     : FIFO empty flag
//   O_VALID/O_DATA : stream output, head of the 2-entry buffer
//   I_READY        : downstream ready
//   O_XFER_CNT     : delivered-word counter, only with FIFO_RD_STREAM_CNT_EN
// Optional feature macro: FIFO_RD_STREAM_CNT_EN
// ---------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DW = RD_STREAM_DW
) (
    input  logic                  I_CLK,
    input  logic                  I_RST_N,
    output logic                  O_RD_REQ,
    input  logic [DW-1:0]         I_RD_DATA,
    input  logic                  I_RD_EMPTY,
    output logic                  O_VALID,
    output logic [DW-1:0]         O_DATA,
`ifdef FIFO_RD_STREAM_CNT_EN
    output logic [XFER_CNT_W-1:0] O_XFER_CNT,
`endif
    input  logic                  I_READY
);

    occ_e       occ;
    logic       inflight_q, inflight_d;
    logic       pop;
    logic [2:0] level;
    logic       rd_req;

    assign pop = O_VALID & I_READY;

    // Request only when the word it brings back is guaranteed a slot:
    // stored words plus the one in flight, minus the one leaving now, must
    // stay below two. The reset term keeps the request low while held.
    always_comb begin
        level      = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
        rd_req     = I_RST_N & ~I_RD_EMPTY & (level < 3'd2);
        inflight_d = rd_req;
    end

    // Remembers that the FIFO will present a word on the next cycle.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_rd_skid #(
        .DW (DW)
    ) u_skid (
        .clk       (I_CLK),
        .rst_n     (I_RST_N),
        .push      (inflight_q),
        .push_data (I_RD_DATA),
        .pop       (pop),
        .head_data (O_DATA),
        .occ       (occ)
    );

    assign O_RD_REQ = rd_req;
    assign O_VALID  = (occ != OCC_EMPTY);

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    // Counts accepted stream words; wraps naturally at the counter width.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (pop) begin
            xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(1);
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign O_XFER_CNT = xfer_cnt_q;
`endif

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits; legal range 1..64.
REQ-002 SHALL have port I_CLK input 1: single clock for all logic.
REQ-003 SHALL have port I_RST_N input 1: asynchronous active-low reset.
REQ-004 SHALL have port O_RD_REQ output 1: read request to the FIFO read port.
REQ-005 SHALL have port I_RD_DATA input DW: FIFO read data, valid exactly one I_CLK cycle after an accepted O_RD_REQ.
REQ-006 SHALL have port I_RD_EMPTY input 1: FIFO empty flag.
REQ-007 SHALL have port O_VALID output 1: stream data valid.
REQ-008 SHALL have port O_DATA output DW: stream data, head of the output buffer.
REQ-009 SHALL have port I_READY input 1: downstream ready.
REQ-010 SHALL have port O_XFER_CNT output 16: delivered-word count, present only when the REQ-024 macro is defined.

Function
REQ-011 SHALL define a transfer as O_VALID=1 and I_READY=1 at a rising I_CLK edge.
REQ-012 SHALL hold a 2-entry in-order output buffer with occupancy state EMPTY(0), ONE(1) or TWO(2).
REQ-013 SHALL hold a 1-bit inflight register, set in the cycle after O_RD_REQ=1 and cleared otherwise.
REQ-014 SHALL drive O_RD_REQ = !I_RD_EMPTY and (occ + inflight - pop) < 2 combinationally, where pop = transfer this cycle.
REQ-015 SHALL never assert O_RD_REQ while I_RD_EMPTY=1.
REQ-016 SHALL write I_RD_DATA into the buffer tail on each cycle with inflight=1, without exception.
REQ-017 SHALL drive O_VALID = (occ != 0) and O_DATA = buffer head, registered with no combinational path from I_RD_DATA.
REQ-018 SHALL hold O_DATA stable while O_VALID=1 and I_READY=0.
REQ-019 SHALL update occupancy per edge as follows.
- EMPTY: capture -> ONE.
- ONE: capture only -> TWO; pop only -> EMPTY; capture and pop -> ONE, new word at head.
- TWO: pop -> ONE; capture in TWO is unreachable by REQ-014.
REQ-020 SHALL sustain one word per cycle in steady state (FIFO non-empty, I_READY=1) after a 2-cycle initial latency from I_RD_EMPTY falling to O_VALID rising.
REQ-021 SHALL preserve FIFO order exactly, with no loss or duplication, under any I_READY pattern.

Reset
REQ-022 SHALL, while I_RST_N=0, force occupancy EMPTY, inflight 0, O_VALID 0, O_DATA 0, O_RD_REQ 0 and O_XFER_CNT 0.
REQ-023 SHALL discard the buffer contents and any in-flight word when reset asserts mid-operation, and resume per REQ-014 from the first edge after release.

Configuration
REQ-024 SHALL, with macro FIFO_RD_STREAM_CNT_EN defined, provide O_XFER_CNT incrementing by 1 per transfer and wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL, without FIFO_RD_STREAM_CNT_EN, omit the O_XFER_CNT port and its counter entirely, with all other behaviour identical.

Structure
REQ-026 SHALL take the default DW and the counter width constant (16) from shared package fifo_pkg, alongside the FIFO's DW and AW defaults.
REQ-027 SHALL implement the 2-entry buffer as sub-module fifo_rd_skid (ports: push, push data, pop, head data, occupancy).

Verification
REQ-028 SHALL cover: reset held, FIFO empty -> O_RD_REQ=0 and O_VALID=0 for 20 cycles.
REQ-029 SHALL cover: FIFO preloaded with 0x11,0x22,0x33, I_READY=1 -> O_VALID rises 2 cycles after reset release; 0x11,0x22,0x33 delivered on consecutive cycles.
REQ-030 SHALL cover: I_READY=0 with 5 words in FIFO -> exactly 2 O_RD_REQ pulses; O_VALID=1 with O_DATA held at first word; occupancy TWO.
REQ-031 SHALL cover: 100 random words with random I_READY (50%) -> output sequence equals input sequence; O_XFER_CNT=100 when the macro is defined.
REQ-032 SHALL cover: reset pulse while occupancy TWO and inflight=1 -> O_VALID=0 next edge; post-release output resumes with the next FIFO word only.
REQ-033 SHALL cover: O_XFER_CNT preset near wrap (0xFFFE) plus 3 transfers -> O_XFER_CNT=0x0001.
